// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths and FSM state encoding for the I2C master core
package i2c_pkg;
  localparam int STATE_W = 4;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  typedef enum logic [STATE_W-1:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    ADDR       = 4'd2,
    ADDR_ACK   = 4'd3,
    WRITE_DATA = 4'd4,
    WRITE_ACK  = 4'd5,
    READ_DATA  = 4'd6,
    READ_NACK  = 4'd7,
    STOP       = 4'd8
  } state_t;
endpackage

// File: rtl/i2c_master_core_if.sv
// i2c_master_core_if: local request side of the I2C master
// addr/data_in/enable/rd_wr flow requester->core, data_out/ready flow core->requester
interface i2c_master_core_if;
  import i2c_pkg::*;
  logic [I2C_ADDR_W-1:0] addr;
  logic [I2C_DATA_W-1:0] data_in;
  logic                  enable;
  logic                  rd_wr;
  logic [I2C_DATA_W-1:0] data_out;
  logic                  ready;
  modport master (output addr, data_in, enable, rd_wr, input data_out, ready);
  modport slave (input addr, data_in, enable, rd_wr, output data_out, ready);
endinterface

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: splits each SCL bit period into four phases of QTR clocks
// ports: clk, rst; phase_o (0..3), qtr_tick_o (last clk of a phase), bit_tick_o (last clk of phase 3)
module i2c_phase_gen #(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] phase_o,
  output logic       qtr_tick_o,
  output logic       bit_tick_o
);
  localparam int CW = QTR > 1 ? $clog2(QTR) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  assign qtr_tick_o = cnt_q == CW'(QTR - 1);
  assign bit_tick_o = qtr_tick_o && phase_q == 2'd3;
  assign phase_o = phase_q;
  assign cnt_d = qtr_tick_o ? '0 : cnt_q + 1'b1;
  assign phase_d = phase_q + 2'(qtr_tick_o);
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      phase_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: single-master I2C controller, one 7-bit address + one byte per transaction
// ports: clk, rst (sync, active-high); req (request interface, slave modport);
//        i2c_sda (open-drain, drives 0 or Z); i2c_scl (open-drain style, drives 0 or Z)
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int QTR = 4
) (
  input logic              clk,
  input logic              rst,
  i2c_master_core_if.slave req,
  inout wire               i2c_sda,
  output wire              i2c_scl
);
  state_t state, state_d;
  logic [1:0] phase;
  logic qtr_tick, bit_tick, samp, scl_hi;
  logic [2:0] bit_q;
  logic [I2C_DATA_W-1:0] tx_q, rx_q, data_q, dout_q;
  logic rw_q, ack_q, ready_q;
  logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  i2c_phase_gen #(.QTR(QTR)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .phase_o    (phase),
    .qtr_tick_o (qtr_tick),
    .bit_tick_o (bit_tick)
  );
  // SDA is sampled on the clock that enters phase 2, mid SCL-high
  assign samp = qtr_tick && phase == 2'd1;
  assign scl_hi = phase == 2'd1 || phase == 2'd2;
  always_comb begin
    state_d = state;
    if (bit_tick)
      case (state)
        IDLE:       state_d = req.enable ? START : IDLE;
        START:      state_d = ADDR;
        ADDR:       state_d = bit_q == 3'd7 ? ADDR_ACK : ADDR;
        ADDR_ACK:   state_d = ack_q ? STOP : (rw_q ? READ_DATA : WRITE_DATA);
        WRITE_DATA: state_d = bit_q == 3'd7 ? WRITE_ACK : WRITE_DATA;
        WRITE_ACK:  state_d = STOP;
        READ_DATA:  state_d = bit_q == 3'd7 ? READ_NACK : READ_DATA;
        READ_NACK:  state_d = STOP;
        default:    state_d = IDLE;
      endcase
  end
  // START holds SCL high through phase 2 so SDA can fall under it; STOP lets SCL rise
  // in phase 1 and SDA in phase 2
  always_comb begin
    scl_oe_d = state == IDLE ? 1'b0 :
               state == START ? phase == 2'd3 :
               state == STOP ? phase == 2'd0 : !scl_hi;
    sda_oe_d = state == START ? phase[1] :
               state == STOP ? !phase[1] :
               (state == ADDR || state == WRITE_DATA) ? !tx_q[7] : 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      data_q <= '0;
      dout_q <= '0;
      rw_q <= 1'b0;
      ack_q <= 1'b1;
      ready_q <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state <= state_d;
      ready_q <= state_d == IDLE;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      if (samp && state == READ_DATA) rx_q <= {rx_q[6:0], i2c_sda};
      if (samp && (state == ADDR_ACK || state == WRITE_ACK)) ack_q <= i2c_sda;
      if (bit_tick) begin
        bit_q <= (state == ADDR || state == WRITE_DATA || state == READ_DATA) ? bit_q + 3'd1 : 3'd0;
        if (state == IDLE && req.enable) begin
          tx_q <= {req.addr, req.rd_wr};
          data_q <= req.data_in;
          rw_q <= req.rd_wr;
        end else if (state == ADDR || state == WRITE_DATA) begin
          tx_q <= tx_q << 1;
        end else if (state == ADDR_ACK) begin
          tx_q <= data_q;
        end
        if (state == READ_NACK) dout_q <= rx_q;
      end
    end
  assign req.data_out = dout_q;
  assign req.ready = ready_q;
  assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;
  assign i2c_scl = scl_oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: directed bench with a bus monitor and an I2C slave model at 7'h01
module tb_i2c_master_core;
  import i2c_pkg::*;
  localparam int QTR = 4;
  localparam logic [6:0] SLV = 7'h01;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire sda, scl;
  pullup (sda);
  pullup (scl);
  always #5 clk = ~clk;
  i2c_master_core_if bus ();
  i2c_master_core #(.QTR(QTR)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .i2c_sda (sda),
    .i2c_scl (scl)
  );
  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_stop = 0, n_bad = 0, n_data = 0;
  logic s_drv = 1'b0, s_rw = 1'b0, s_mack = 1'b0;
  logic p_sda = 1'b1, p_scl = 1'b1;
  int s_st = 0, s_cnt = 0;
  logic [7:0] s_sh = '0, s_reg = '0, s_abyte = '0;
  assign sda = s_drv ? 1'b0 : 1'bz;
  // slave model: s_st 0 idle, 1 address, 2 write data, 3 read data, 4 ignore until STOP
  always @(sda, scl) begin
    if (scl === 1'b1 && p_scl === 1'b1 && sda !== p_sda) begin
      if (sda === 1'b0) begin
        n_start++;
        if (dut.state != START && dut.state != IDLE) n_bad++;
        s_st = 1;
        s_cnt = 0;
        s_drv = 1'b0;
      end else begin
        n_stop++;
        if (dut.state != STOP && dut.state != IDLE) n_bad++;
        s_st = 0;
        s_drv = 1'b0;
      end
    end else if (scl === 1'b1 && p_scl !== 1'b1 && s_st != 0) begin
      if (s_cnt < 8 && s_st < 3) s_sh = {s_sh[6:0], sda === 1'b1};
      if (s_st == 3 && s_cnt == 8) s_mack = sda === 1'b1;
      s_cnt++;
    end else if (scl === 1'b0 && p_scl === 1'b1 && s_st != 0) begin
      if (s_cnt == 8) begin
        if (s_st == 1) begin
          s_abyte = s_sh;
          s_rw = s_sh[0];
          if (s_sh[7:1] == SLV) s_drv = 1'b1;
          else s_st = 4;
        end else if (s_st == 2) begin
          s_reg = s_sh;
          s_drv = 1'b1;
        end else s_drv = 1'b0;
      end else if (s_cnt == 9) begin
        s_cnt = 0;
        s_drv = 1'b0;
        if (s_st == 1 && s_rw) begin
          s_st = 3;
          s_drv = !s_reg[7];
        end else s_st = s_st == 1 ? 2 : 4;
      end else if (s_st == 3) s_drv = !s_reg[7-s_cnt];
    end
    p_sda = sda;
    p_scl = scl;
  end
  always @(posedge clk) if (dut.state >= WRITE_DATA && dut.state <= READ_NACK) n_data++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_for(input logic [3:0] v, input bit eq, input string tag);
    int n = 0;
    while (((dut.state == v) != eq) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st0, sp0, d0, quiet_bad;
    bus.addr = SLV;
    bus.data_in = 8'h00;
    bus.enable = 1'b0;
    bus.rd_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'h00);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.ready), 32'd1);
    st0 = n_start;
    sp0 = n_stop;
    bus.data_in = 8'hAA;
    bus.enable = 1'b1;
    wait_for(4'd0, 1'b0, "t1_go");
    wait_for(4'd0, 1'b1, "t1_done");
    chk("t1_reg", 32'(s_reg), 32'hAA);
    chk("t1_abyte", 32'(s_abyte), 32'h02);
    chk("t1_starts", 32'(n_start - st0), 32'd1);
    chk("t1_stops", 32'(n_stop - sp0), 32'd1);
    bus.data_in = 8'h0F;
    wait_for(4'd0, 1'b0, "t2_go");
    bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_busy", 32'(bus.ready), 32'd0);
    wait_for(4'd0, 1'b1, "t2_done");
    chk("t2_ready", 32'(bus.ready), 32'd1);
    chk("t2_reg", 32'(s_reg), 32'h0F);
    chk("t2_dout_hold", 32'(bus.data_out), 32'h00);
    repeat (8 * QTR) @(posedge clk);
    s_reg = 8'h5A;
    bus.rd_wr = 1'b1;
    bus.enable = 1'b1;
    wait_for(4'd0, 1'b0, "t3_go");
    bus.enable = 1'b0;
    wait_for(4'd0, 1'b1, "t3_done");
    chk("t3_dout", 32'(bus.data_out), 32'h5A);
    chk("t3_nack", 32'(s_mack), 32'd1);
    chk("t3_abyte", 32'(s_abyte), 32'h03);
    repeat (8 * QTR) @(posedge clk);
    d0 = n_data;
    sp0 = n_stop;
    bus.addr = 7'h22;
    bus.enable = 1'b1;
    wait_for(4'd0, 1'b0, "t4_go");
    bus.enable = 1'b0;
    wait_for(4'd0, 1'b1, "t4_done");
    chk("t4_dout", 32'(bus.data_out), 32'h5A);
    chk("t4_no_data", 32'(n_data - d0), 32'd0);
    chk("t4_stops", 32'(n_stop - sp0), 32'd1);
    repeat (8 * QTR) @(posedge clk);
    bus.addr = SLV;
    bus.rd_wr = 1'b0;
    bus.data_in = 8'h33;
    bus.enable = 1'b1;
    wait_for(4'(WRITE_DATA), 1'b1, "t5_wd");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_state", 32'(dut.state), 32'd0);
    chk("t5_scl", 32'(scl), 32'd1);
    chk("t5_sda", 32'(sda), 32'd1);
    chk("t5_ready_rst", 32'(bus.ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready !== 1'b1 || scl !== 1'b1 || sda !== 1'b1 || dut.state != IDLE) quiet_bad++;
    end
    chk("t6_quiet", 32'(quiet_bad), 32'd0);
    chk("bus_edges", 32'(n_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
